// File: rtl/rdm_pkg.sv
// Shared types and default geometry for the receive resource demapper slot sequencer.
package rdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } rdm_state_t;

    localparam int RDM_SYMS      = 7;
    localparam int RDM_DMRS_IDX  = 3;
    localparam int RDM_ISC_MAX   = 4;
    localparam int RDM_ADDR_W    = 4;
    localparam int RDM_DATA_SYMS = RDM_SYMS - 1;

    // Last RAM address of a slot: data symbols are stored at 0..syms-2.
    function automatic int rdm_last_ptr(input int syms);
        return syms - 2;
    endfunction

endpackage

// File: rtl/rdm_ptr_ctr.sv
// Clearable, enabled wrap counter used for the symbol, write and read pointers.
module rdm_ptr_ctr
    import rdm_pkg::*;
#(
    parameter int P_W   = 4,
    parameter int P_MAX = 5
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clr,
    input  logic           i_en,
    output logic [P_W-1:0] o_cnt
);

    localparam logic [P_W-1:0] L_MAX = P_W'(P_MAX);

    logic [P_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == L_MAX) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/rdm_slot_sequencer.sv
// Slot sequencer: writes FFT data symbols into the demapper RAMs, skips DMRS,
// then reads the stored slot back to equalisation under downstream flow control.
module rdm_slot_sequencer
    import rdm_pkg::*;
#(
    parameter int P_SYMS     = RDM_SYMS,
    parameter int P_DMRS_IDX = RDM_DMRS_IDX,
    parameter int P_ISC_MAX  = RDM_ISC_MAX,
    parameter int P_ADDR_W   = RDM_ADDR_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_fft_valid,
    input  logic [5:0]          i_isc,
    input  logic                i_out_ready,
    output logic                o_dp_en,
    output logic                o_ram_en,
    output logic                o_we,
    output logic [P_ADDR_W-1:0] o_addr,
    output logic                o_dmrs_valid,
    output logic                o_rd_valid,
    output logic [2:0]          o_valid_count,
    output logic                o_slot_done,
    output logic                o_isc_err,
    output logic                o_overrun
);

    localparam int L_SYM_W = $clog2(P_SYMS);
    localparam logic [L_SYM_W-1:0]  L_DMRS    = L_SYM_W'(P_DMRS_IDX);
    localparam logic [L_SYM_W-1:0]  L_SYM_END = L_SYM_W'(P_SYMS - 1);
    localparam logic [P_ADDR_W-1:0] L_RD_LAST = P_ADDR_W'(rdm_last_ptr(P_SYMS));
    localparam logic [5:0]          L_ISC_MAX = 6'(P_ISC_MAX);

    rdm_state_t          r_state;
    logic                r_dp_en;
    logic                r_ram_en;
    logic                r_we;
    logic [P_ADDR_W-1:0] r_addr;
    logic                r_dmrs_valid;
    logic                r_rd_valid;
    logic [2:0]          r_valid_count;
    logic                r_slot_done;
    logic                r_isc_err;
    logic                r_overrun;
    logic                r_rd_iss;
    logic [2:0]          r_rd_ord;

    logic [L_SYM_W-1:0]  w_sym_cnt;
    logic [P_ADDR_W-1:0] w_wr_ptr;
    logic [P_ADDR_W-1:0] w_rd_ptr;
    logic                w_wr_phase;
    logic                w_rd_phase;
    logic                w_isc_ok;
    logic                w_acc;
    logic                w_dmrs;
    logic                w_wr;
    logic                w_last;
    logic                w_issue;
    logic                w_rd_last;

    assign w_wr_phase = (r_state == ST_IDLE) || (r_state == ST_WRITE);
    assign w_rd_phase = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign w_isc_ok   = (i_isc <= L_ISC_MAX);
    assign w_acc      = i_fft_valid && w_wr_phase && w_isc_ok;
    assign w_dmrs     = w_acc && (w_sym_cnt == L_DMRS);
    assign w_wr       = w_acc && !w_dmrs;
    assign w_last     = w_acc && (w_sym_cnt == L_SYM_END);
    assign w_issue    = (r_state == ST_READ) && i_out_ready;
    assign w_rd_last  = (w_rd_ptr == L_RD_LAST);

    rdm_ptr_ctr #(.P_W(L_SYM_W), .P_MAX(P_SYMS - 1)) u_sym_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_last),
        .i_en  (w_acc),
        .o_cnt (w_sym_cnt)
    );

    rdm_ptr_ctr #(.P_W(P_ADDR_W), .P_MAX(P_SYMS - 2)) u_wr_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_last),
        .i_en  (w_wr),
        .o_cnt (w_wr_ptr)
    );

    rdm_ptr_ctr #(.P_W(P_ADDR_W), .P_MAX(P_SYMS - 2)) u_rd_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (r_state == ST_DRAIN),
        .i_en  (w_issue),
        .o_cnt (w_rd_ptr)
    );

    // Read data appears one cycle after the issue, so the ordinal rides a one-stage pipe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_dp_en       <= 1'b0;
            r_ram_en      <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_dmrs_valid  <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_valid_count <= 3'd0;
            r_slot_done   <= 1'b0;
            r_isc_err     <= 1'b0;
            r_overrun     <= 1'b0;
            r_rd_iss      <= 1'b0;
            r_rd_ord      <= 3'd0;
        end else begin
            r_ram_en      <= 1'b0;
            r_we          <= 1'b0;
            r_dmrs_valid  <= 1'b0;
            r_slot_done   <= 1'b0;
            r_rd_iss      <= 1'b0;
            r_isc_err     <= i_fft_valid && w_wr_phase && !w_isc_ok;
            r_overrun     <= i_fft_valid && w_rd_phase;
            r_rd_valid    <= r_rd_iss;
            r_valid_count <= r_rd_iss ? r_rd_ord : 3'd0;
            case (r_state)
                ST_IDLE, ST_WRITE: begin
                    r_dp_en <= 1'b1;
                    if (w_acc) begin
                        if (w_dmrs) begin
                            r_dmrs_valid <= 1'b1;
                        end else begin
                            r_ram_en <= 1'b1;
                            r_we     <= 1'b1;
                            r_addr   <= w_wr_ptr;
                        end
                        if (w_last) begin
                            r_state <= ST_READ;
                            r_dp_en <= 1'b0;
                        end else begin
                            r_state <= ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    r_dp_en <= 1'b0;
                    if (i_out_ready) begin
                        r_ram_en <= 1'b1;
                        r_addr   <= w_rd_ptr;
                        r_rd_iss <= 1'b1;
                        r_rd_ord <= 3'(w_rd_ptr) + 3'd1;
                        if (w_rd_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_slot_done <= 1'b1;
                    r_dp_en     <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_dp_en <= 1'b0;
                end
            endcase
        end
    end

    assign o_dp_en       = r_dp_en;
    assign o_ram_en      = r_ram_en;
    assign o_we          = r_we;
    assign o_addr        = r_addr;
    assign o_dmrs_valid  = r_dmrs_valid;
    assign o_rd_valid    = r_rd_valid;
    assign o_valid_count = r_valid_count;
    assign o_slot_done   = r_slot_done;
    assign o_isc_err     = r_isc_err;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_rdm_slot_sequencer.sv
// Directed bench for rdm_slot_sequencer: slot writes, DMRS skip, illegal offsets,
// read backpressure, overrun, back-to-back slots and mid-slot reset.
module tb_rdm_slot_sequencer;
    import rdm_pkg::*;

    logic       i_clk;
    logic       i_rst;
    logic       i_fft_valid;
    logic [5:0] i_isc;
    logic       i_out_ready;
    logic       o_dp_en;
    logic       o_ram_en;
    logic       o_we;
    logic [3:0] o_addr;
    logic       o_dmrs_valid;
    logic       o_rd_valid;
    logic [2:0] o_valid_count;
    logic       o_slot_done;
    logic       o_isc_err;
    logic       o_overrun;

    logic [14:0] w_all_out;
    int n_chk;
    int n_fail;

    rdm_slot_sequencer u_dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_fft_valid   (i_fft_valid),
        .i_isc         (i_isc),
        .i_out_ready   (i_out_ready),
        .o_dp_en       (o_dp_en),
        .o_ram_en      (o_ram_en),
        .o_we          (o_we),
        .o_addr        (o_addr),
        .o_dmrs_valid  (o_dmrs_valid),
        .o_rd_valid    (o_rd_valid),
        .o_valid_count (o_valid_count),
        .o_slot_done   (o_slot_done),
        .o_isc_err     (o_isc_err),
        .o_overrun     (o_overrun)
    );

    assign w_all_out = {o_dp_en, o_ram_en, o_we, o_addr, o_dmrs_valid, o_rd_valid,
                        o_valid_count, o_slot_done, o_isc_err, o_overrun};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // kind: 0 = write expected at addr, 1 = DMRS, 2 = illegal offset
    task automatic send_sym(input logic [5:0] isc, input int kind, input int addr);
        i_fft_valid = 1'b1;
        i_isc       = isc;
        @(negedge i_clk);
        i_fft_valid = 1'b0;
        check_eq("we",        32'(o_we),         32'(kind == 0));
        check_eq("ram_en_wr", 32'(o_ram_en),     32'(kind == 0));
        check_eq("dmrs",      32'(o_dmrs_valid), 32'(kind == 1));
        check_eq("isc_err",   32'(o_isc_err),    32'(kind == 2));
        if (kind == 0) check_eq("wr_addr", 32'(o_addr), 32'(addr));
    endtask

    task automatic gap(input int n);
        @(negedge i_clk);
        check_eq("pulse_clear", 32'({o_we, o_dmrs_valid, o_isc_err, o_overrun}), 32'd0);
        repeat (n - 1) @(negedge i_clk);
    endtask

    task automatic read_phase(input logic [7:0] pat, input int ovr_at);
        int  e_rd;
        int  po;
        int  k;
        bit  pi;
        bit  done;
        bit  rdy;
        bit  iss;
        e_rd = 0; po = 0; k = 0; pi = 0; done = 0;
        while (!done && k < 40) begin
            rdy         = pat[k % 8];
            i_out_ready = rdy;
            i_fft_valid = (k == ovr_at);
            i_isc       = 6'd2;
            @(negedge i_clk);
            i_fft_valid = 1'b0;
            iss = rdy && (e_rd < RDM_DATA_SYMS);
            check_eq("rd_ram_en", 32'(o_ram_en), 32'(iss));
            check_eq("rd_we",     32'(o_we), 32'd0);
            if (iss) check_eq("rd_addr", 32'(o_addr), 32'(e_rd));
            check_eq("rd_valid",    32'(o_rd_valid),    32'(pi));
            check_eq("valid_count", 32'(o_valid_count), pi ? 32'(po) : 32'd0);
            check_eq("slot_done",   32'(o_slot_done),   32'(pi && po == 6));
            check_eq("overrun",     32'(o_overrun),     32'(k == ovr_at));
            if (pi && po == 6) done = 1;
            check_eq("rd_dp_en", 32'(o_dp_en), 32'(done));
            po = e_rd + 1;
            pi = iss;
            if (iss) e_rd++;
            k++;
        end
        if (!done) check_eq("rd_timeout", 32'd0, 32'd1);
    endtask

    // Seven legal symbols (DMRS at index 3); optional illegal offset before legal symbol err_pos.
    task automatic run_slot(input int err_pos, input logic [7:0] pat, input int ovr_at);
        for (int i = 0; i < 7; i++) begin
            if (i == err_pos) begin
                send_sym(6'd9, 2, 0);
                gap(1);
            end
            send_sym(6'd2, (i == 3) ? 1 : 0, (i < 3) ? i : i - 1);
            if (i < 6) gap(3);
        end
        read_phase(pat, ovr_at);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        i_rst = 1'b1;
        i_fft_valid = 1'b0;
        i_isc = 6'd0;
        i_out_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        check_eq("reset_outputs", 32'(w_all_out), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_eq("idle_dp_en", 32'(o_dp_en), 32'd1);

        run_slot(-1, 8'hFF, -1);
        gap(2);
        run_slot(1, 8'hFF, -1);
        gap(2);
        run_slot(-1, 8'h55, 2);
        @(negedge i_clk);
        check_eq("slot_done_single", 32'(o_slot_done), 32'd0);
        run_slot(-1, 8'hFF, -1);
        gap(2);

        send_sym(6'd2, 0, 0);
        gap(3);
        send_sym(6'd2, 0, 1);
        gap(3);
        send_sym(6'd2, 0, 2);
        i_rst = 1'b1;
        #1;
        check_eq("rst_mid_outputs", 32'(w_all_out), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_eq("rst_mid_dp_en", 32'(o_dp_en), 32'd1);
        run_slot(-1, 8'hFF, -1);
        gap(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
